sigma_delta_adc_arbiter: RTL and testbench

Collects decimated samples from NUM_CHANNELS sigma_delta_adc instances and serialises them onto one valid/ready stream tagged with a channel ID.
- Sequences per-channel startup by discarding the first DISCARD_SAMPLES outputs after reset or enable, which covers the CIC/FIR settling transient.
- Buffers one sample per channel and flags overruns.
- Sits between the ADC bank and the downstream sample sink (FIFO, UART or I2S packer).

---
 rtl/sigma_delta_pkg.sv | 18 +
 rtl/sigma_delta_adc_arbiter_rr_arbiter.sv | 39 +++
 rtl/sigma_delta_adc_arbiter.sv | 154 +++++++++++++++
 tb/tb_sigma_delta_adc_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// Shared types and width helpers for the sigma-delta ADC arbiter slice.
//   ch_state_t : per-channel startup state (off / discarding / running)
//   width_of   : bits needed to index n items (at least 1)
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    CH_OFF,
    CH_DISCARD,
    CH_RUN
  } ch_state_t;

  // Bits required to encode values 0..n-1; never returns 0 so that
  // degenerate parameter choices still give legal vector widths.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sigma_delta_adc_arbiter_rr_arbiter.sv
// Round-robin priority select over NUM_CHANNELS requesters.
//   req        : request vector
//   last_grant : index granted most recently; search starts one above it
//   grant      : one-hot grant
//   grant_idx  : binary index of the granted requester
//   any_grant  : at least one request present
// Purely combinational; the caller owns and updates last_grant.
module rr_arbiter
  import sigma_delta_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  localparam int unsigned CH_W = width_of(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [CH_W-1:0]         last_grant,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [CH_W-1:0]         grant_idx,
  output logic                    any_grant
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    // Offsets 1..N cover every requester once, ending on last_grant itself.
    for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
      idx = CH_W'((32'(last_grant) + k) % NUM_CHANNELS);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sigma_delta_adc_arbiter.sv
// Serialises decimated samples from a bank of sigma-delta ADCs onto a single
// valid/ready stream tagged with the source channel.
//   clk, rst        : clock, asynchronous active-high reset
//   ch_enable       : per-channel enable; a channel re-runs its startup discard
//                     after every enable
//   adc_output_bus  : channel i sample at [i*ADC_BITLEN +: ADC_BITLEN]
//   adc_valid       : per-channel one-cycle sample strobe
//   m_data/m_channel/m_valid/m_ready : output stream
//   overrun         : sticky flag, a buffered sample was replaced before sent
//   overrun_clr     : clears all overrun flags (a same-cycle set wins)
module sigma_delta_adc_arbiter
  import sigma_delta_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned ADC_BITLEN      = 24,
  parameter int unsigned DISCARD_SAMPLES = 4,
  localparam int unsigned CH_W = width_of(NUM_CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CHANNELS-1:0]          ch_enable,
  input  logic [NUM_CHANNELS*ADC_BITLEN-1:0] adc_output_bus,
  input  logic [NUM_CHANNELS-1:0]          adc_valid,
  output logic [ADC_BITLEN-1:0]            m_data,
  output logic [CH_W-1:0]                  m_channel,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [NUM_CHANNELS-1:0]          overrun,
  input  logic                             overrun_clr
);

  localparam int unsigned     CNT_W   = width_of(DISCARD_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DISCARD_SAMPLES);

  ch_state_t                 state_q [NUM_CHANNELS];
  ch_state_t                 state_d [NUM_CHANNELS];
  logic [CNT_W-1:0]          cnt_q   [NUM_CHANNELS];
  logic [CNT_W-1:0]          cnt_d   [NUM_CHANNELS];
  logic [ADC_BITLEN-1:0]     hold_q  [NUM_CHANNELS];
  logic [ADC_BITLEN-1:0]     hold_d  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]   pending_q, pending_d;
  logic [NUM_CHANNELS-1:0]   overrun_q, overrun_d;
  logic [NUM_CHANNELS-1:0]   capture, ov_set, granted;
  logic [ADC_BITLEN-1:0]     m_data_q, m_data_d;
  logic [CH_W-1:0]           m_channel_q, m_channel_d;
  logic                      m_valid_q, m_valid_d;
  logic [CH_W-1:0]           last_grant_q, last_grant_d;

  logic                      load;
  logic [NUM_CHANNELS-1:0]   grant;
  logic [CH_W-1:0]           grant_idx;
  logic                      any_grant;

  assign load = !m_valid_q || m_ready;

  // A channel disabled this cycle loses its pending sample, so it must not
  // win the output register at the same time.
  rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_rr (
    .req        (pending_q & ch_enable),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  always_comb begin
    granted = (load && any_grant) ? grant : '0;
    capture = '0;
    ov_set  = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      hold_d[i]    = hold_q[i];
      pending_d[i] = pending_q[i] & ~granted[i];
      if (!ch_enable[i]) begin
        state_d[i]   = CH_OFF;
        cnt_d[i]     = '0;
        pending_d[i] = 1'b0;
      end else begin
        unique case (state_q[i])
          CH_OFF: begin
            state_d[i] = CH_DISCARD;
            cnt_d[i]   = '0;
          end
          CH_DISCARD: begin
            if (DISCARD_SAMPLES == 0) begin
              state_d[i] = CH_RUN;
              capture[i] = adc_valid[i];
            end else if (adc_valid[i] && cnt_q[i] != CNT_MAX) begin
              // The strobe completing the count is itself dropped.
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
              if (cnt_q[i] + CNT_W'(1) == CNT_MAX) state_d[i] = CH_RUN;
            end
          end
          CH_RUN:  capture[i] = adc_valid[i];
          default: state_d[i] = CH_OFF;
        endcase
      end
      if (capture[i]) begin
        hold_d[i]    = adc_output_bus[i*ADC_BITLEN +: ADC_BITLEN];
        pending_d[i] = 1'b1;
        ov_set[i]    = pending_q[i] & ~granted[i];
      end
    end
    overrun_d = (overrun_clr ? '0 : overrun_q) | ov_set;

    m_data_d     = m_data_q;
    m_channel_d  = m_channel_q;
    m_valid_d    = m_valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      m_valid_d = any_grant;
      if (any_grant) begin
        m_data_d     = hold_q[grant_idx];
        m_channel_d  = grant_idx;
        last_grant_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= CH_DISCARD;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
      end
      pending_q    <= '0;
      overrun_q    <= '0;
      m_data_q     <= '0;
      m_channel_q  <= '0;
      m_valid_q    <= 1'b0;
      last_grant_q <= CH_W'(NUM_CHANNELS - 1);
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
      end
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      m_data_q     <= m_data_d;
      m_channel_q  <= m_channel_d;
      m_valid_q    <= m_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_channel = m_channel_q;
  assign m_valid   = m_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sigma_delta_adc_arbiter.sv
// Self-checking bench for sigma_delta_adc_arbiter: directed scenarios plus a
// randomized phase, all compared cycle by cycle with a behavioural model.
module tb_sigma_delta_adc_arbiter;

  localparam int N  = 4;
  localparam int W  = 24;
  localparam int DS = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   ch_enable;
  logic [N*W-1:0] adc_output_bus;
  logic [N-1:0]   adc_valid;
  logic [W-1:0]   m_data;
  logic [1:0]     m_channel;
  logic           m_valid;
  logic           m_ready;
  logic [N-1:0]   overrun;
  logic           overrun_clr;

  sigma_delta_adc_arbiter #(
    .NUM_CHANNELS    (N),
    .ADC_BITLEN      (W),
    .DISCARD_SAMPLES (DS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ch_enable      (ch_enable),
    .adc_output_bus (adc_output_bus),
    .adc_valid      (adc_valid),
    .m_data         (m_data),
    .m_channel      (m_channel),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .overrun        (overrun),
    .overrun_clr    (overrun_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: per channel, how many strobes are still to be thrown
  // away, whether it sat disabled, one buffered sample, and the output slot.
  int           skip [N];
  bit           was_off [N];
  bit           pend [N];
  logic [W-1:0] hold [N];
  bit   [N-1:0] ov;
  bit           mv;
  logic [W-1:0] md;
  int           mc;
  int           lg;

  // Transfers seen on the DUT stream, as {channel, data}.
  logic [W+1:0] xfer_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      skip[i] = DS; was_off[i] = 0; pend[i] = 0; hold[i] = '0;
    end
    ov = '0; mv = 0; md = '0; mc = 0; lg = N - 1;
  endtask

  task automatic model_step();
    bit   load;
    int   g;
    bit   [N-1:0] ov_next;
    load = !mv || m_ready;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (lg + k) % N;
      if (g < 0 && pend[c] && ch_enable[c]) g = c;
    end
    if (load) begin
      if (g >= 0) begin
        md = hold[g]; mc = g; mv = 1; lg = g;
      end else begin
        mv = 0;
      end
    end
    ov_next = overrun_clr ? '0 : ov;
    for (int i = 0; i < N; i++) begin
      bit taken, cap;
      taken = load && (g == i);
      cap = 0;
      if (!ch_enable[i]) begin
        was_off[i] = 1;
        pend[i] = 0;
      end else if (was_off[i]) begin
        was_off[i] = 0;
        skip[i] = DS;
      end else if (adc_valid[i]) begin
        if (skip[i] > 0) skip[i]--;
        else cap = 1;
      end
      if (ch_enable[i]) begin
        if (cap) begin
          if (pend[i] && !taken) ov_next[i] = 1;
          hold[i] = adc_output_bus[i*W +: W];
          pend[i] = 1;
        end else if (taken) begin
          pend[i] = 0;
        end
      end
    end
    ov = ov_next;
  endtask

  task automatic compare_outputs();
    chk("m_valid", 32'(m_valid), 32'(mv));
    chk("overrun", 32'(overrun), 32'(ov));
    if (mv) begin
      chk("m_data", 32'(m_data), 32'(md));
      chk("m_channel", 32'(m_channel), 32'(mc));
    end
  endtask

  // One clock: log any transfer, step model on the edge, check just after.
  task automatic cycle();
    if (m_valid && m_ready) xfer_log.push_back({m_channel, m_data});
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    adc_valid = '0;
    overrun_clr = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic strobe(input logic [N-1:0] mask, input logic [W-1:0] base);
    for (int i = 0; i < N; i++) adc_output_bus[i*W +: W] = base + W'(i * 16);
    adc_valid = mask;
    cycle();
    adc_valid = '0;
  endtask

  task automatic strobe_one(input int ch, input logic [W-1:0] val);
    adc_output_bus[ch*W +: W] = val;
    adc_valid = '0;
    adc_valid[ch] = 1'b1;
    cycle();
    adc_valid = '0;
  endtask

  task automatic chk_log(input string tag, input int idx, input int ch, input logic [W-1:0] data);
    logic [W+1:0] e;
    e = {ch[1:0], data};
    if (idx < xfer_log.size()) chk(tag, 32'(xfer_log[idx]), 32'(e));
    else chk(tag, 32'hDEAD_BEEF, 32'(e));
  endtask

  initial begin
    rst = 1; ch_enable = '1; adc_output_bus = '0; adc_valid = '0;
    m_ready = 1; overrun_clr = 0;
    model_reset();
    #1;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_m_channel", 32'(m_channel), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 0;

    // Startup discard: k=0..3 are dropped, k=4,5 reach the stream.
    xfer_log.delete();
    for (int k = 0; k < 6; k++) begin
      strobe('1, W'(k));
      idle(5);
    end
    idle(4);
    chk("discard_count", 32'(xfer_log.size()), 32'd8);
    for (int k = 4; k < 6; k++)
      for (int i = 0; i < N; i++)
        chk_log("discard_seq", (k - 4) * N + i, i, W'(i * 16 + k));
    chk("discard_overrun", 32'(overrun), 32'd0);

    // Round-robin fairness, twice so last_grant wraps from 3 back to 0.
    for (int rep = 0; rep < 2; rep++) begin
      xfer_log.delete();
      strobe('1, W'(32'hA00 + rep * 32'h100));
      idle(6);
      for (int i = 0; i < N; i++)
        chk_log("rr_seq", i, i, W'(32'hA00 + rep * 32'h100 + i * 16));
    end

    // Backpressure with overwrite on ch1.
    m_ready = 0;
    strobe_one(0, 24'h000111);
    strobe_one(1, 24'hAAAAAA);
    strobe_one(1, 24'h555555);
    idle(7);
    chk("stall_hold_data", 32'(m_data), 32'h000111);
    chk("stall_overrun1", 32'(overrun[1]), 32'd1);
    xfer_log.delete();
    m_ready = 1;
    idle(4);
    chk_log("bp_first", 0, 0, 24'h000111);
    chk_log("bp_newest", 1, 1, 24'h555555);

    // Clear coinciding with a new overrun on ch0: the set wins, ch1 clears.
    m_ready = 0;
    strobe_one(3, 24'h000333);
    idle(1);
    strobe_one(0, 24'h0000A0);
    overrun_clr = 1;
    strobe_one(0, 24'h0000B0);
    overrun_clr = 0;
    chk("clr_vs_set", 32'(overrun), 32'h1);
    overrun_clr = 1;
    cycle();
    overrun_clr = 0;
    chk("clr_all", 32'(overrun), 32'h0);
    m_ready = 1;
    idle(4);

    // Grant and new valid on ch2 in the same cycle: no overrun.
    m_ready = 0;
    strobe_one(0, 24'h0000C0);
    idle(1);
    strobe_one(2, 24'h111111);
    xfer_log.delete();
    m_ready = 1;
    strobe_one(2, 24'h123456);
    idle(4);
    chk("coincide_overrun2", 32'(overrun[2]), 32'd0);
    chk_log("coincide_a", 0, 0, 24'h0000C0);
    chk_log("coincide_b", 1, 2, 24'h111111);
    chk_log("coincide_c", 2, 2, 24'h123456);

    // Disable ch3 for 3 cycles: discard restarts on re-enable.
    ch_enable = 4'b0111;
    idle(3);
    ch_enable = '1;
    idle(1);
    xfer_log.delete();
    for (int k = 0; k < 6; k++) begin
      strobe_one(3, W'(32'h300 + k));
      idle(2);
    end
    idle(2);
    chk("reenable_count", 32'(xfer_log.size()), 32'd2);
    chk_log("reenable_a", 0, 3, 24'h000304);
    chk_log("reenable_b", 1, 3, 24'h000305);

    // Randomized traffic, enables and clears.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) adc_output_bus[i*W +: W] = W'($urandom);
      for (int i = 0; i < N; i++) adc_valid[i] = ($urandom_range(9, 0) < 3);
      m_ready = ($urandom_range(3, 0) != 0);
      overrun_clr = ($urandom_range(31, 0) == 0);
      if ($urandom_range(63, 0) == 0) begin
        int c;
        c = $urandom_range(N - 1, 0);
        ch_enable[c] = ~ch_enable[c];
      end
      cycle();
    end
    adc_valid = '0; overrun_clr = 0; m_ready = 1; ch_enable = '1;
    idle(8);

    // Asynchronous reset mid-burst.
    strobe('1, 24'h00F000);
    idle(1);
    #2;
    rst = 1;
    #1;
    chk("async_rst_m_valid", 32'(m_valid), 32'd0);
    chk("async_rst_overrun", 32'(overrun), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
